// File: rtl/i2c_target.sv
// I2C target: matches DEV_ADDR, first written byte loads the pointer, then writes or reads a register file with auto-increment.
// Latency: pins are seen 3 clk late (2-flop sync + history); all outputs are registered one clk after the detected bus event.
// Backpressure: none; the backend must accept every wr_en pulse and present rd_data combinationally from rd_addr.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         REG_AW   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [REG_AW-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              rd_strobe,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  localparam logic [REG_AW-1:0] PTR_ONE = REG_AW'(1);

  // [0],[1] synchronizer stages, [2] history for edge detection
  logic [2:0] scl_sync_q, sda_sync_q;
  logic       scl_s, scl_h, sda_s, sda_h;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              rw_q, rw_d;
  logic              first_q, first_d;
  // ACK states: 0 = waiting for the fall that starts driving, 1 = driving.
  // RD_ACK: 1 = master acknowledged, next fall loads the next byte.
  logic              phase_q, phase_d;
  logic [REG_AW-1:0] ptr_q, ptr_d;
  logic              ptr_inc_q, ptr_inc_d;
  logic              sda_oe_q, sda_oe_d;
  logic              wr_en_q, wr_en_d;
  logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              rd_strobe_q, rd_strobe_d;
  logic              busy_q, busy_d;

  // Bring the asynchronous pins into the clk domain; reset to idle-high so no false event follows reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], scl_i};
      sda_sync_q <= {sda_sync_q[1:0], sda_i};
    end
  end

  assign scl_s     = scl_sync_q[1];
  assign scl_h     = scl_sync_q[2];
  assign sda_s     = sda_sync_q[1];
  assign sda_h     = sda_sync_q[2];
  assign scl_rise  = scl_s & ~scl_h;
  assign scl_fall  = ~scl_s & scl_h;
  assign start_det = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;
  assign rx_byte   = {shift_q[6:0], sda_s};

  // Next-state and output logic; bus conditions override any bit event in the same clk
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    first_d     = first_q;
    phase_d     = phase_q;
    ptr_d       = ptr_inc_q ? ptr_q + PTR_ONE : ptr_q;
    ptr_inc_d   = 1'b0;
    sda_oe_d    = sda_oe_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_strobe_d = 1'b0;
    busy_d      = busy_q;

    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      phase_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (shift_q[6:0] == DEV_ADDR) begin
              state_d = ADDR_ACK;
              busy_d  = 1'b1;
              rw_d    = sda_s;
              phase_d = 1'b0;
            end else begin
              state_d = WAIT_STOP;
              busy_d  = 1'b0;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d = 1'b1;
            phase_d  = 1'b1;
          end else begin
            phase_d   = 1'b0;
            bit_cnt_d = 3'd0;
            if (rw_q) begin
              state_d     = RD_BYTE;
              rd_strobe_d = 1'b1;
              shift_d     = rd_data;
              sda_oe_d    = ~rd_data[7];
            end else begin
              state_d  = WR_BYTE;
              first_d  = 1'b1;
              sda_oe_d = 1'b0;
            end
          end
        end
        WR_BYTE: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = WR_ACK;
            phase_d = 1'b0;
            if (first_q) begin
              ptr_d   = REG_AW'(rx_byte);
              first_d = 1'b0;
            end else begin
              wr_en_d   = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = rx_byte;
              ptr_inc_d = 1'b1;
            end
          end
        end
        WR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d = 1'b1;
            phase_d  = 1'b1;
          end else begin
            sda_oe_d  = 1'b0;
            phase_d   = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = WR_BYTE;
          end
        end
        // Rotate rather than shift so the register always holds the byte being sent
        RD_BYTE: if (scl_fall) begin
          if (bit_cnt_q == 3'd7) begin
            sda_oe_d = 1'b0;
            phase_d  = 1'b0;
            state_d  = RD_ACK;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {shift_q[6:0], shift_q[7]};
            sda_oe_d  = ~shift_q[6];
          end
        end
        RD_ACK: begin
          if (scl_rise && !phase_q) begin
            if (!sda_s) begin
              ptr_d   = ptr_q + PTR_ONE;
              phase_d = 1'b1;
            end else begin
              state_d  = WAIT_STOP;
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
            end
          end else if (scl_fall && phase_q) begin
            state_d     = RD_BYTE;
            rd_strobe_d = 1'b1;
            shift_d     = rd_data;
            sda_oe_d    = ~rd_data[7];
            bit_cnt_d   = 3'd0;
            phase_d     = 1'b0;
          end
        end
        IDLE, WAIT_STOP: sda_oe_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; reset releases SDA without waiting for clk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      rw_q        <= 1'b0;
      first_q     <= 1'b0;
      phase_q     <= 1'b0;
      ptr_q       <= '0;
      ptr_inc_q   <= 1'b0;
      sda_oe_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'd0;
      rd_strobe_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      first_q     <= first_d;
      phase_q     <= phase_d;
      ptr_q       <= ptr_d;
      ptr_inc_q   <= ptr_inc_d;
      sda_oe_q    <= sda_oe_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_strobe_q <= rd_strobe_d;
      busy_q      <= busy_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_addr   = ptr_q;
  assign rd_strobe = rd_strobe_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-level I2C master, open-drain bus, register-file backend.
// Expected traffic comes from a transaction-level model (pointer, memory image, queues).
// A negedge monitor checks every backend strobe and SDA stability while SCL is high.
module tb_i2c_target;

  localparam logic [6:0] DEV = 7'h50;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_bus;
  logic       sda_oe, wr_en, rd_strobe, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

  logic [7:0]  mem   [256];
  logic [7:0]  m_mem [256];
  logic [7:0]  m_ptr;
  logic [15:0] exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];
  logic [15:0] wr_log [$];
  logic [7:0]  rd_log [$];
  logic [7:0]  rx_log [$];
  logic [7:0]  txb [$];
  int          strobe_cnt = 0;
  int          errors = 0;
  int          checks = 0;

  logic scl_prev = 1'b1, oe_prev = 1'b0, rst_prev = 1'b0;

  assign sda_bus = m_sda & ~sda_oe;
  assign rd_data = mem[rd_addr];

  always #5 clk = ~clk;

  i2c_target #(.DEV_ADDR(7'h50), .REG_AW(8)) dut (
    .clk(clk), .reset_n(reset_n), .scl_i(m_scl), .sda_i(sda_bus),
    .sda_oe(sda_oe), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_strobe(rd_strobe), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: backend strobes against the model queues, SDA stability while SCL high
  always @(negedge clk) begin
    if (reset_n && rst_prev) begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
        wr_log.push_back({wr_addr, wr_data});
        check("wr_en_expected", 32'(exp_wr_q.size() != 0), 1);
        if (exp_wr_q.size() != 0) begin
          check("wr_addr_data", 32'({wr_addr, wr_data}), 32'(exp_wr_q[0]));
          void'(exp_wr_q.pop_front());
        end
      end
      if (rd_strobe) begin
        strobe_cnt++;
        rd_log.push_back(rd_addr);
        check("rd_strobe_expected", 32'(exp_rd_q.size() != 0), 1);
        if (exp_rd_q.size() != 0) begin
          check("rd_addr_at_strobe", 32'(rd_addr), 32'(exp_rd_q[0]));
          void'(exp_rd_q.pop_front());
        end
      end
      if (scl_prev && m_scl)
        check("sda_oe_stable_scl_high", 32'(sda_oe), 32'(oe_prev));
    end
    scl_prev <= m_scl;
    oe_prev  <= sda_oe;
    rst_prev <= reset_n;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCL period: SDA set mid-low, sampled mid-high
  task automatic clock_bit(input logic b, output logic smp, output logic oe_smp);
    m_sda = b;
    wait_clks(5);
    m_scl = 1'b1;
    wait_clks(5);
    smp    = sda_bus;
    oe_smp = sda_oe;
    wait_clks(5);
    m_scl = 1'b0;
    wait_clks(5);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    wait_clks(5);
    m_scl = 1'b1;
    wait_clks(10);
    m_sda = 1'b0;
    wait_clks(10);
    m_scl = 1'b0;
    wait_clks(5);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    wait_clks(5);
    m_scl = 1'b1;
    wait_clks(10);
    m_sda = 1'b1;
    wait_clks(10);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    logic s, oe, any_oe;
    any_oe = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(b[i], s, oe);
      any_oe = any_oe | oe;
    end
    check({tag, "_no_drive_in_data"}, 32'(any_oe), 0);
    clock_bit(1'b1, s, oe);
    check({tag, "_ack"}, 32'(oe), 32'(exp_ack));
    check({tag, "_busy"}, 32'(busy), 32'(exp_ack));
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] got);
    logic s, oe;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s, oe);
      got[i] = s;
    end
    clock_bit(ack ? 1'b0 : 1'b1, s, oe);
    check("released_in_master_ack", 32'(oe), 0);
  endtask

  // Model-driven write: address byte then every byte in txb
  task automatic xfer_write(input logic [6:0] a, input logic do_stop);
    logic match;
    match = (a == DEV);
    i2c_start();
    send_byte({a, 1'b0}, match, "addr_w");
    for (int i = 0; i < txb.size(); i++) begin
      if (match) begin
        if (i == 0) m_ptr = txb[0];
        else begin
          exp_wr_q.push_back({m_ptr, txb[i]});
          m_mem[m_ptr] = txb[i];
          m_ptr = m_ptr + 8'd1;
        end
      end
      send_byte(txb[i], match, "data_w");
    end
    if (do_stop) begin
      i2c_stop();
      wait_clks(5);
      check("busy_after_stop", 32'(busy), 0);
      check("oe_after_stop", 32'(sda_oe), 0);
    end
  endtask

  // Model-driven read of n bytes from the current pointer; last byte NACKed
  task automatic xfer_read(input int n);
    logic [7:0] got, exp;
    logic ack;
    i2c_start();
    exp_rd_q.push_back(m_ptr);
    send_byte({DEV, 1'b1}, 1'b1, "addr_r");
    for (int k = 0; k < n; k++) begin
      ack = (k < n - 1);
      exp = m_mem[m_ptr];
      if (ack) exp_rd_q.push_back(m_ptr + 8'd1);
      recv_byte(ack, got);
      check("rd_byte", 32'(got), 32'(exp));
      rx_log.push_back(got);
      if (ack) m_ptr = m_ptr + 8'd1;
    end
    check("oe_after_nack", 32'(sda_oe), 0);
    check("busy_after_nack", 32'(busy), 0);
    i2c_stop();
    wait_clks(5);
  endtask

  initial begin
    logic s, oe;
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 8'(i * 7 + 3);
      m_mem[i] = 8'(i * 7 + 3);
    end
    mem[8'h10] = 8'h9E; m_mem[8'h10] = 8'h9E;
    mem[8'h11] = 8'h21; m_mem[8'h11] = 8'h21;
    mem[8'h01] = 8'h77; m_mem[8'h01] = 8'h77;
    mem[8'h20] = 8'h0F; m_mem[8'h20] = 8'h0F;
    m_ptr = 8'h00;

    // Reset state
    wait_clks(4);
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_rd_strobe", 32'(rd_strobe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    reset_n = 1'b1;
    wait_clks(10);

    // Write: pointer 0x03, two data bytes
    wr_log.delete();
    txb = {8'h03, 8'h5A, 8'hC3};
    xfer_write(DEV, 1'b1);
    check("wr_count_write", 32'(wr_log.size()), 2);
    check("wr0_literal", 32'(wr_log[0]), 'h035A);
    check("wr1_literal", 32'(wr_log[1]), 'h04C3);

    // Random read: pointer 0x10, repeated START, two bytes
    wr_log.delete(); rx_log.delete(); strobe_cnt = 0;
    txb = {8'h10};
    xfer_write(DEV, 1'b0);
    xfer_read(2);
    check("rx0_literal", 32'(rx_log[0]), 'h9E);
    check("rx1_literal", 32'(rx_log[1]), 'h21);
    check("strobe_count_read", 32'(strobe_cnt), 2);
    check("no_wr_in_read", 32'(wr_log.size()), 0);

    // Address mismatch
    wr_log.delete();
    txb = {8'h55};
    xfer_write(7'h51, 1'b1);
    check("no_wr_mismatch", 32'(wr_log.size()), 0);

    // Pointer wrap, then read continues at 0x01
    wr_log.delete(); rx_log.delete(); rd_log.delete();
    txb = {8'hFF, 8'h11, 8'h22};
    xfer_write(DEV, 1'b1);
    check("wrap_wr0_literal", 32'(wr_log[0]), 'hFF11);
    check("wrap_wr1_literal", 32'(wr_log[1]), 'h0022);
    xfer_read(1);
    check("wrap_rd_addr_literal", 32'(rd_log[0]), 'h01);
    check("wrap_rx_literal", 32'(rx_log[0]), 'h77);

    // Abort after 4 data bits, then a clean write
    wr_log.delete();
    txb = {8'h40};
    xfer_write(DEV, 1'b0);
    clock_bit(1'b1, s, oe);
    clock_bit(1'b0, s, oe);
    clock_bit(1'b1, s, oe);
    clock_bit(1'b0, s, oe);
    i2c_stop();
    wait_clks(5);
    check("abort_oe", 32'(sda_oe), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_no_wr", 32'(wr_log.size()), 0);
    txb = {8'h40, 8'h99};
    xfer_write(DEV, 1'b1);
    check("after_abort_wr_literal", 32'(wr_log[0]), 'h4099);

    // Reset while the target drives a 0 data bit
    wr_log.delete();
    txb = {8'h20};
    xfer_write(DEV, 1'b0);
    i2c_start();
    exp_rd_q.push_back(m_ptr);
    send_byte({DEV, 1'b1}, 1'b1, "addr_r_rst");
    check("drive_msb0_literal", 32'(sda_oe), 1);
    clock_bit(1'b1, s, oe);
    check("bit7_on_bus_literal", 32'(s), 0);
    check("drive_bit6_literal", 32'(sda_oe), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_release", 32'(sda_oe), 0);
    check("rst_ptr", 32'(rd_addr), 0);
    check("rst_busy_mid", 32'(busy), 0);
    m_ptr = 8'h00;
    m_scl = 1'b1;
    m_sda = 1'b1;
    wait_clks(5);
    reset_n = 1'b1;
    wait_clks(10);
    txb = {8'h30, 8'hAB};
    xfer_write(DEV, 1'b1);
    check("post_reset_wr_literal", 32'(wr_log[0]), 'h30AB);

    check("all_writes_seen", 32'(exp_wr_q.size()), 0);
    check("all_strobes_seen", 32'(exp_rd_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) that sits on the same `scl`/`sda` bus the APB-to-I2C bridge masters, i.e. the responder end of that link.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a fixed 7-bit device address and ACKs it; the first written byte loads a register pointer.
- Subsequent bytes are written to, or read from, a simple register-file backend with pointer auto-increment.

Parameters:
- DEV_ADDR, 7'h50, 7-bit device address the target responds to.
- REG_AW, 8, register pointer / backend address width; the pointer wraps modulo 2^REG_AW.

Ports:
- clk  input  1  system clock; must be >= 10x SCL frequency.
- reset_n  input  1  asynchronous active-low reset.
- scl_i  input  1  SCL pin level, asynchronous.
- sda_i  input  1  SDA pin level, asynchronous.
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- wr_en  output  1  one-clk pulse: write wr_data to wr_addr.
- wr_addr  output  REG_AW  backend write address.
- wr_data  output  8  backend write data.
- rd_addr  output  REG_AW  current pointer, used as backend read address.
- rd_data  input  8  backend read data; combinational from rd_addr.
- rd_strobe  output  1  one-clk pulse when rd_data is captured for transmission.
- busy  output  1  1 from an address-matched START until STOP, mismatch or NACK.

Behaviour:
- **Clock and reset.** One clock domain. Reset is asynchronous, active-low. In reset: sda_oe=0, wr_en=0, rd_strobe=0, busy=0, wr_addr=0, wr_data=0, pointer/rd_addr=0, FSM=IDLE. Asserting reset mid-transfer releases SDA immediately, without waiting for clk.
- **Input conditioning.** scl_i and sda_i each pass through a 2-flop synchronizer plus a history flop.
  - scl_rise/scl_fall: synchronized edges of SCL.
  - START: SDA 1->0 while SCL held 1.
  - STOP: SDA 0->1 while SCL held 1.
- **Global events.**
  - START (including repeated START) in any state -> ADDR, bit_cnt=0, sda_oe=0. Pointer is retained.
  - STOP in any state -> IDLE, sda_oe=0, busy=0. A partial byte is discarded with no wr_en.
- **Bit timing.** SDA is sampled on scl_rise, MSB first, with a 3-bit bit counter. sda_oe changes only on the clk following scl_fall detection, never while SCL is high.
- **FSM states:** IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
  - IDLE: wait for START.
  - ADDR: shift 8 bits. On the 8th rise:
    - address == DEV_ADDR -> ADDR_ACK, busy=1, latch R/W.
    - otherwise -> WAIT_STOP, never driving SDA.
  - ADDR_ACK: on the next scl_fall drive sda_oe=1; on the following scl_fall release it and go to:
    - R/W=0: WR_BYTE, with first_byte flag set.
    - R/W=1: RD_BYTE. On the ACK-release fall, pulse rd_strobe, load shift <= rd_data and drive sda_oe=~shift[7].
  - WR_BYTE: on the 8th rise:
    - first_byte: pointer <= byte.
    - else: wr_en=1 for one clk with wr_addr=pointer and wr_data=byte; pointer <= pointer+1 one clk later.
    - Then go to WR_ACK, which always ACKs (drive on fall, release on next fall) and returns to WR_BYTE.
  - RD_BYTE: drive sda_oe=~bit on each scl_fall for bits 6..0. After bit 0's scl_fall, release and go to RD_ACK.
  - RD_ACK: sample SDA on the 9th rise.
    - 0 (ACK): pointer+1, then on the next fall pulse rd_strobe, load rd_data and drive the MSB.
    - 1 (NACK): WAIT_STOP, sda_oe=0, busy=0.
  - WAIT_STOP: idle-release until START or STOP.
- **Pointer.** Wraps 2^REG_AW-1 -> 0 in both directions of transfer. rd_addr equals the pointer.
- **Simultaneous events.** START/STOP take priority over any bit event in the same clk. A wr_en already pulsed is never retracted.

Test Plan:
- Write: START, 0xA0, 0x03, 0x5A, 0xC3, STOP -> ACK (sda_oe=1) in every 9th bit. wr_en pulses exactly twice, with (0x03,0x5A) then (0x04,0xC3). busy falls at STOP.
- Random read: START, 0xA0, 0x10, Sr, 0xA1; master ACKs byte 1 and NACKs byte 2; mem[0x10]=0x9E, mem[0x11]=0x21.
  - SDA carries 0x9E then 0x21; rd_strobe pulses twice.
  - sda_oe=0 after the NACK; no wr_en at any point.
- Mismatch: START, 0xA2, 0x55, STOP -> sda_oe stays 0 throughout, no wr_en, busy stays 0.
- Wrap: write pointer 0xFF, data 0x11, 0x22 -> wr_en with wr_addr 0xFF then 0x00. A following read starts at 0x01.
- Abort: STOP after 4 data bits -> FSM=IDLE, no wr_en, sda_oe=0. The next full write completes normally.
- Reset mid-read while driving a 0 bit -> sda_oe=0 asynchronously, pointer=0. After release, the target responds to a fresh START/0xA0.
